accel_seq_feeder: RTL

Stream-side sequencer sitting directly upstream of the bit-manipulation accelerator slave in the Avalon fabric. Accepts 32-bit words with an op code on a valid/ready input stream and drives the accelerator's addr/rd_en/wr_en/writedata port with the required write, increment and read cycles. Captures the combinational readdata and buffers results in a small output FIFO for a valid/ready consumer, such as the DMA or logging path. Replaces HPS-side polling of the accelerator with a hardware pipeline.

---
 rtl/accel_seq_feeder_pkg.sv | 37 +++
 rtl/accel_seq_feeder_sync_fifo.sv | 60 ++++++
 rtl/accel_seq_feeder.sv | 115 +++++++++++
 3 files changed

// File: rtl/accel_seq_feeder_pkg.sv
// Shared definitions for the accelerator stream feeder: operation codes carried
// on the input stream, accelerator register addresses and the sequencer states.
package accel_seq_feeder_pkg;

    // Operation requested alongside each operand word.
    typedef enum logic [1:0] {
        OP_REV = 2'b00,
        OP_INC = 2'b01,
        OP_INV = 2'b10,
        OP_RAW = 2'b11
    } op_e;

    // Accelerator register map.
    localparam logic [1:0] ACC_REG_DATA = 2'b00;
    localparam logic [1:0] ACC_REG_INC  = 2'b01;
    localparam logic [1:0] ACC_REG_INV  = 2'b10;

    // Sequencer states: one write, optional increment, one read.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WR   = 2'b01,
        ST_INC  = 2'b10,
        ST_RD   = 2'b11
    } state_e;

    // Register read back to obtain the result of a given operation.
    // RAW reads the plain data view, which lives at the increment address.
    function automatic logic [1:0] result_addr(input op_e op);
        case (op)
            OP_REV:  return ACC_REG_DATA;
            OP_INC:  return ACC_REG_INC;
            OP_INV:  return ACC_REG_INV;
            default: return ACC_REG_INC;
        endcase
    endfunction

endpackage

// File: rtl/accel_seq_feeder_sync_fifo.sv
// Synchronous FIFO with occupancy count.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset (empties the FIFO)
//   push_i, push_data_i : write request and data
//   pop_i             : read request; ignored when empty
//   head_o            : current head entry (meaningless when empty)
//   valid_o           : FIFO non-empty
//   count_o           : number of stored entries, 0..DEPTH
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_COUNT) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/accel_seq_feeder.sv
// Stream-side sequencer for the bit-manipulation accelerator slave.
// Takes operand+op words from a valid/ready stream, runs the write / increment /
// read cycles on the accelerator port and queues the read results in a FIFO.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   in_data/in_op/in_valid/in_ready : operand stream (accept on valid&ready)
//   out_data/out_valid/out_ready    : result stream (FIFO head, pop on valid&ready)
//   acc_addr/acc_wr_en/acc_rd_en/acc_writedata/acc_readdata : accelerator port
//   busy                : a transaction is in flight
//   out_count           : result FIFO occupancy
module accel_seq_feeder
    import accel_seq_feeder_pkg::*;
#(
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [31:0]                  in_data,
    input  logic [1:0]                   in_op,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [31:0]                  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   acc_addr,
    output logic                         acc_wr_en,
    output logic                         acc_rd_en,
    output logic [31:0]                  acc_writedata,
    input  logic [31:0]                  acc_readdata,
    output logic                         busy,
    output logic [$clog2(OUT_DEPTH):0]   out_count
);

    localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] data_q, data_d;
    logic        ready_en_q;
    logic        push;
    logic        accept;

    // ready_en_q holds in_ready low until the first clock edge after reset.
    assign in_ready = ready_en_q && (state_q == ST_IDLE) && (out_count < CW'(OUT_DEPTH));
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_REV;
            data_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        data_d        = data_q;
        acc_addr      = ACC_REG_DATA;
        acc_wr_en     = 1'b0;
        acc_rd_en     = 1'b0;
        acc_writedata = '0;
        push          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = op_e'(in_op);
                    data_d  = in_data;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                acc_addr      = ACC_REG_DATA;
                acc_wr_en     = 1'b1;
                acc_writedata = data_q;
                state_d       = (op_q == OP_INC) ? ST_INC : ST_RD;
            end
            ST_INC: begin
                acc_addr  = ACC_REG_INC;
                acc_wr_en = 1'b1;
                state_d   = ST_RD;
            end
            ST_RD: begin
                acc_addr  = result_addr(op_q);
                acc_rd_en = 1'b1;
                push      = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH(32),
        .DEPTH(OUT_DEPTH)
    ) u_out_fifo (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .push_i      (push),
        .push_data_i (acc_readdata),
        .pop_i       (out_ready),
        .head_o      (out_data),
        .valid_o     (out_valid),
        .count_o     (out_count)
    );

endmodule
